// File: rtl/mbc_pop_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mbc_pop_fifo
// Brief    : Receive-side FIFO from the system bus to the memory bus
//            controller. Buffers 64-bit packets and presents them
//            first-word-fall-through. It also reports sticky overflow,
//            underflow and end-of-boot flags.
// Options  : `define MBC_FIFO_AFULL_EN to build the almost_full comparator.
//            Without it, almost_full is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mbc_pop_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter int AF_MARGIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   d_in,
  input  logic          psh_in,
  input  logic          pop,
  output logic [63:0]   d_pop,
  output logic          pndng,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic          boot_done
);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("mbc_pop_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_bad_margin
    $error("mbc_pop_fifo: AF_MARGIN must satisfy 1 <= AF_MARGIN < DEPTH");
  end

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          pop_acc;
  logic          push_acc;
  logic          head_is_boot_end;

  assign pndng    = (cnt != '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign d_pop    = pndng ? mem[rp] : 64'h0;

  // A pop is only honoured when there is something to pop. A push into a
  // full FIFO is still legal if the head leaves on the same edge.
  assign pop_acc  = pop & pndng;
  assign push_acc = psh_in & (~full | pop_acc);

  // End-of-boot packet: source SPI/boot (01) and command 3.
  assign head_is_boot_end = (d_pop[61:60] == 2'b01) && (d_pop[59:57] == 3'd3);

`ifdef MBC_FIFO_AFULL_EN
  assign almost_full = (cnt >= (AW+1)'(DEPTH - AF_MARGIN));
`else
  assign almost_full = 1'b0;
`endif

  // Storage array: written on accepted pushes only. It is never cleared.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      mem[wp] <= d_in;
    end
  end

  // Pointers, occupancy and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      if (push_acc) begin
        wp <= wp + AW'(1);
      end
      if (pop_acc) begin
        rp <= rp + AW'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (psh_in && full && !pop_acc) begin
        ovf <= 1'b1;
      end
      if (pop && !pndng) begin
        udf <= 1'b1;
      end
      if (pop_acc && head_is_boot_end) begin
        boot_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mbc_pop_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbc_pop_fifo
// Brief    : Self-checking bench for mbc_pop_fifo. It uses directed scenarios
//            followed by randomized push/pop/reset traffic. Every result is
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbc_pop_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] d_in;
  logic        psh_in;
  logic        pop;
  logic [63:0] d_pop;
  logic        pndng;
  logic        full;
  logic        almost_full;
  logic [AW:0] count;
  logic        ovf;
  logic        udf;
  logic        boot_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [63:0] q[$];
  bit          m_ovf;
  bit          m_udf;
  bit          m_boot;
  bit          model_valid = 0;

  always #5 clk = ~clk;

  mbc_pop_fifo #(.DEPTH(DEPTH), .AF_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .psh_in(psh_in), .pop(pop),
    .d_pop(d_pop), .pndng(pndng), .full(full), .almost_full(almost_full),
    .count(count), .ovf(ovf), .udf(udf), .boot_done(boot_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the FIFO rules.
  task automatic model_edge(input bit p, input logic [63:0] d, input bit po, input bit r);
    bit was_full;
    bit pa;
    logic [63:0] head;
    if (!r) begin
      q.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_boot = 0;
      model_valid = 1;
      return;
    end
    was_full = (q.size() == DEPTH);
    pa = po && (q.size() != 0);
    if (po && q.size() == 0) m_udf = 1;
    if (p && was_full && !pa) m_ovf = 1;
    if (pa) begin
      head = q.pop_front();
      if (head[61:60] == 2'b01 && head[59:57] == 3'd3) m_boot = 1;
    end
    if (p && (!was_full || pa)) q.push_back(d);
  endtask

  task automatic check_outputs();
    logic [63:0] exp_head;
    bit exp_af;
    exp_head = (q.size() != 0) ? q[0] : 64'h0;
`ifdef MBC_FIFO_AFULL_EN
    exp_af = (q.size() >= DEPTH - 2);
`else
    exp_af = 0;
`endif
    chk("count",       64'(count),       64'(q.size()));
    chk("pndng",       64'(pndng),       64'(q.size() != 0));
    chk("full",        64'(full),        64'(q.size() == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(exp_af));
    chk("d_pop",       d_pop,            exp_head);
    chk("ovf",         64'(ovf),         64'(m_ovf));
    chk("udf",         64'(udf),         64'(m_udf));
    chk("boot_done",   64'(boot_done),   64'(m_boot));
  endtask

  // Drive one cycle of stimulus. Outputs are checked 1 ns after the edge.
  task automatic step(input bit p, input logic [63:0] d, input bit po, input bit r);
    @(negedge clk);
    psh_in = p;
    d_in   = d;
    pop    = po;
    reset  = r;
    @(posedge clk);
    model_edge(p, d, po, r);
    #1;
    if (model_valid) check_outputs();
  endtask

  function automatic logic [63:0] pkt(input logic [1:0] src, input logic [2:0] cmd,
                                      input logic [31:0] data);
    return {2'b00, src, cmd, 25'h0, data};
  endfunction

  initial begin
    psh_in = 0;
    pop    = 0;
    d_in   = '0;
    reset  = 0;

    // Reset, then three pushes and three pops.
    step(0, 64'h0, 0, 0);
    step(0, 64'h0, 0, 0);
    step(1, 64'hA1, 0, 1);
    step(1, 64'hA2, 0, 1);
    step(1, 64'hA3, 0, 1);
    repeat (3) step(0, 64'h0, 1, 1);

    // Fill to full, overflow, then a push and pop on the same edge while full.
    for (int i = 0; i < DEPTH; i++) step(1, 64'hB0 + 64'(i), 0, 1);
    step(1, 64'hDEAD, 0, 1);
    step(1, 64'hC0, 1, 1);
    repeat (DEPTH) step(0, 64'h0, 1, 1);

    // Pop on an empty FIFO with a simultaneous push.
    step(1, 64'h55, 1, 1);
    step(0, 64'h0, 1, 1);

    // End-of-boot detection. A non-boot source with command 3 must not count.
    step(0, 64'h0, 0, 0);
    step(1, pkt(2'b10, 3'd3, 32'h1), 0, 1);
    step(1, pkt(2'b01, 3'd0, 32'h2), 0, 1);
    step(1, pkt(2'b01, 3'd3, 32'h3), 0, 1);
    repeat (3) step(0, 64'h0, 1, 1);

    // Fill to 5, then reset while pushing.
    for (int i = 0; i < 5; i++) step(1, 64'hE0 + 64'(i), 0, 1);
    step(1, 64'hEE, 1, 0);
    step(0, 64'h0, 0, 1);

    // Walk occupancy up to full and back down to cover almost_full.
    for (int i = 0; i < DEPTH; i++) step(1, 64'hF0 + 64'(i), 0, 1);
    repeat (DEPTH) step(0, 64'h0, 1, 1);

    // Randomized traffic with alternating fill-heavy and drain-heavy phases.
    for (int c = 0; c < 3000; c++) begin
      bit fill_phase;
      bit p;
      bit po;
      bit r;
      logic [63:0] d;
      fill_phase = ((c / 48) % 2) == 0;
      p  = fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      po = fill_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      r  = ($urandom_range(0, 399) != 0);
      d  = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) d[61:57] = {2'b01, 3'd3};
      step(p, d, po, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mbc_pop_fifo.md
# mbc_pop_fifo

Receive-side FIFO between the system bus and the memory bus controller (MBC). It buffers 64-bit bus packets (boot words during the boot phase, I/O responses afterwards) and presents them first-word-fall-through on `d_pop`/`pndng`, dequeuing on the MBC's `pop_mbc` strobe. It also flags overflow, underflow and the end-of-boot packet so the bus side can throttle and the system can monitor boot completion.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `AW`, $clog2(DEPTH): pointer width; derived, not overridden.
- `AF_MARGIN`, 2: almost-full margin (used only with `MBC_FIFO_AFULL_EN`); 1 ≤ AF_MARGIN < DEPTH.

- `clk` input 1 — single clock, all state on rising edge.
- `reset` input 1 — synchronous, active-low (0 = reset).
- `d_in` input 64 — packet from bus: [61:60] source (1 = SPI/boot), [59:57] command, [33+max:34] word address, [31:0] data.
- `psh_in` input 1 — bus push strobe, one entry per cycle high.
- `pop` input 1 — dequeue strobe, driven by the MBC's `pop_mbc`.
- `d_pop` output 64 — head entry; 0 when empty.
- `pndng` output 1 — FIFO not empty.
- `full` output 1 — count == DEPTH.
- `almost_full` output 1 — count ≥ DEPTH−AF_MARGIN (macro-dependent).
- `count` output AW+1 — current occupancy, 0..DEPTH.
- `ovf` output 1 — sticky: push attempted while full.
- `udf` output 1 — sticky: pop attempted while empty.
- `boot_done` output 1 — sticky: end-of-boot packet dequeued.

## Operation
- Storage: DEPTH×64 register array. Write pointer `wp`, read pointer `rp` (AW bits, natural wrap DEPTH−1→0). Occupancy counter `count` (AW+1 bits).
- Push accepted when `psh_in & (~full | pop_acc)`; writes `d_in` at `wp`, `wp` increments.
- `pop_acc = pop & pndng`; `rp` increments.
- Push while full without a same-cycle pop: dropped; `ovf` set; array, pointers and count unchanged.
- Pop while empty: ignored; `udf` set.
- Simultaneous accepted push and pop: count unchanged, both pointers advance. When full, this case is legal and does not set `ovf`. When empty, the pop is not accepted (`udf` set) and the push proceeds, so count becomes 1.
- `d_pop = pndng ? mem[rp] : 64'h0`, read combinationally from registered state (first-word fall-through).
- `pndng = (count != 0)`, `full = (count == DEPTH)`.
- `boot_done` is set on an accepted pop whose head has [61:60]==2'b01 and [59:57]==3'd3.
- Sticky flags `ovf`, `udf` and `boot_done` clear only on reset.
- Reset (`reset`==0 at a rising edge) has priority over push/pop that cycle. Resulting values: `wp`=`rp`=0, `count`=0, `ovf`=`udf`=`boot_done`=0. Array contents are not cleared.
- Output values under reset: `d_pop`=0, `pndng`=0, `full`=0, `almost_full`=0, `count`=0, plus the three flags above at 0.

## Timing
- Push to visibility: a push at edge N makes the entry visible on `d_pop`/`pndng` after edge N. An entry pushed into an empty FIFO is presented the next cycle; there is no same-cycle bypass.
- Pop: the head advances after the edge on which `pop_acc` is sampled. The next entry, or 0 if the FIFO is now empty, appears in the same cycle `pndng` updates.
- Back-to-back pops every cycle are supported, for a throughput of one entry per cycle in each direction.
- `full`, `almost_full` and `count` are registered-state decodes and reflect the edge just taken. The bus side must sample `full` before asserting `psh_in`.
- Reset mid-operation: outputs reach reset values one edge after `reset` is sampled low. In-flight entries are lost.

## Configuration
- `MBC_FIFO_AFULL_EN` defined: `almost_full = (count >= DEPTH-AF_MARGIN)`, giving the bus early backpressure.
- `MBC_FIFO_AFULL_EN` undefined: `almost_full` is tied to 0, `AF_MARGIN` is unused, and no comparator is built. All other behaviour is identical.

## Test plan
- Reset, then push 3 packets 0x…A1, 0x…A2, 0x…A3 on consecutive cycles → `count` = 1, 2, 3. `d_pop` = A1 from the cycle after the first push. Three pops → A2, A3, then 0 with `pndng`=0.
- DEPTH=8: 8 pushes → `full`=1. 9th push alone → `ovf`=1, `count`=8, head unchanged. Push+pop in the same cycle while full → `ovf` stays as is, `count`=8, `wp`/`rp` wrap to 1.
- Empty FIFO, `pop`=1 with `psh_in`=1 carrying 0x55 → `udf`=1, `count`=1, `d_pop`=0x55 next cycle.
- Push boot word ([61:60]=1, [59:57]=0), then end packet ([61:60]=1, [59:57]=3), then pop both → `boot_done`=0 after first pop, 1 after second. A [61:60]=2, [59:57]=3 packet never sets `boot_done`.
- Fill to 5 entries, drive `reset`=0 for one edge with `psh_in`=1 → all outputs 0, push dropped, `ovf`/`udf`/`boot_done` cleared.
- With `MBC_FIFO_AFULL_EN`, DEPTH=8, AF_MARGIN=2: `almost_full` rises on the push making count 6 and falls on the pop making count 5. Without the macro → `almost_full`=0 throughout.
